vend_sequencer: RTL

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vend_sequencer.sv
// vend_sequencer: coin-credit vending FSM with dispenser and change-hopper handshakes.
// Optional feature macro VEND_CHANGE_EN: builds the CHANGE state (cancel refund and greedy change).
module vend_sequencer #(
  parameter int unsigned PRICE    = 7,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_code,
  input  logic                cancel,
  input  logic                disp_ack,
  input  logic                change_ack,
  output logic                disp_req,
  output logic                change_valid,
  output logic [1:0]          change_code,
  output logic                coin_reject,
  output logic                vend_done,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COLLECT  = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_C   = {1'b0, {CREDIT_W{1'b1}}};

  // Unit value of a coin code (25p coin is 5 units).
  function automatic logic [CREDIT_W-1:0] coin_units(input logic [1:0] code);
    case (code)
      2'd1:    coin_units = CREDIT_W'(1);
      2'd2:    coin_units = CREDIT_W'(2);
      2'd3:    coin_units = CREDIT_W'(5);
      default: coin_units = '0;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                disp_req_q, disp_req_d;
  logic                coin_reject_q, coin_reject_d;
  logic                vend_done_q, vend_done_d;

  logic                coin_present_c;
  logic                coin_ok_c;
  logic                cancel_eff_c;
  logic [CREDIT_W:0]   credit_sum_c;
  logic [CREDIT_W-1:0] remainder_c;

`ifdef VEND_CHANGE_EN
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_code_q, change_code_d;
  logic [CREDIT_W-1:0] change_rem_c;

  // Largest coin that does not exceed the remaining credit.
  function automatic logic [1:0] change_pick(input logic [CREDIT_W-1:0] cr);
    if (cr >= CREDIT_W'(5))      change_pick = 2'd3;
    else if (cr >= CREDIT_W'(2)) change_pick = 2'd2;
    else                         change_pick = 2'd1;
  endfunction

  assign cancel_eff_c = cancel;
`else
  logic unused_change_inputs;
  assign unused_change_inputs = ^{cancel, change_ack};
  assign cancel_eff_c         = 1'b0;
`endif

  // Coin acceptance: only while collecting below price, no overflow, no pending cancel.
  assign coin_present_c = coin_valid && (coin_code != 2'd0);
  assign credit_sum_c   = {1'b0, credit_q} + {1'b0, coin_units(coin_code)};
  assign coin_ok_c      = ((state_q == ST_IDLE) ||
                           ((state_q == ST_COLLECT) && (credit_q < PRICE_C))) &&
                          (credit_sum_c <= MAX_C) && !cancel_eff_c;
  assign remainder_c    = credit_q - PRICE_C;

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    vend_done_d   = 1'b0;
    coin_reject_d = coin_present_c && !coin_ok_c;
`ifdef VEND_CHANGE_EN
    change_valid_d = change_valid_q;
    change_code_d  = change_code_q;
    change_rem_c   = credit_q - coin_units(change_code_q);
`endif
    case (state_q)
      ST_IDLE: begin
        if (coin_present_c && coin_ok_c) begin
          credit_d = credit_sum_c[CREDIT_W-1:0];
          state_d  = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (cancel_eff_c) begin
          state_d = ST_CHANGE;
        end else if (credit_q >= PRICE_C) begin
          state_d = ST_DISPENSE;
        end else if (coin_present_c && coin_ok_c) begin
          credit_d = credit_sum_c[CREDIT_W-1:0];
        end
      end
      ST_DISPENSE: begin
        if (disp_ack) begin
          credit_d    = remainder_c;
          vend_done_d = 1'b1;
          if (remainder_c == '0) begin
            state_d = ST_IDLE;
          end else begin
`ifdef VEND_CHANGE_EN
            state_d = ST_CHANGE;
`else
            state_d = ST_COLLECT;
`endif
          end
        end
      end
      ST_CHANGE: begin
`ifdef VEND_CHANGE_EN
        // Valid drops after each ack, giving a gap cycle before the next coin.
        if (change_valid_q && change_ack) begin
          credit_d       = change_rem_c;
          change_valid_d = 1'b0;
          change_code_d  = 2'd0;
          if (change_rem_c == '0) state_d = ST_IDLE;
        end else if (!change_valid_q) begin
          if (credit_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            change_valid_d = 1'b1;
            change_code_d  = change_pick(credit_q);
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    disp_req_d = (state_d == ST_DISPENSE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      disp_req_q    <= 1'b0;
      coin_reject_q <= 1'b0;
      vend_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_req_q    <= disp_req_d;
      coin_reject_q <= coin_reject_d;
      vend_done_q   <= vend_done_d;
    end
  end

`ifdef VEND_CHANGE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      change_valid_q <= 1'b0;
      change_code_q  <= 2'd0;
    end else begin
      change_valid_q <= change_valid_d;
      change_code_q  <= change_code_d;
    end
  end

  assign change_valid = change_valid_q;
  assign change_code  = change_code_q;
`else
  assign change_valid = 1'b0;
  assign change_code  = 2'd0;
`endif

  assign disp_req    = disp_req_q;
  assign coin_reject = coin_reject_q;
  assign vend_done   = vend_done_q;
  assign credit      = credit_q;
  assign state       = state_q;

endmodule
